// File: rtl/ssd_scan_n.sv
// ssd_scan_n: N-digit multiplexed seven-segment scan controller.
// Hex nibbles, decimal points and per-digit enables are loaded into a shadow
// register and copied to the active set at each frame boundary. Every digit gets
// a 2^SLOT_W-cycle slot. A 16-level PWM gates each slot. Cathodes and anodes
// are active-low and registered.
// Optional feature: define SSD_LZS_EN to enable leading-zero suppression.
module ssd_scan_n #(
    parameter int unsigned DIGITS = 4,
    parameter int unsigned SLOT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   value_in,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic [DIGITS-1:0]     digit_en_in,
    input  logic [3:0]            bright,
    output logic [6:0]            seg,
    output logic                  dp_n,
    output logic [DIGITS-1:0]     an,
    output logic                  frame_done
);

    localparam int unsigned IdxW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(DIGITS - 1);

    logic [SLOT_W-1:0]   slot_cnt_q, slot_cnt_d;
    logic [IdxW-1:0]     idx_q, idx_d;
    logic [4*DIGITS-1:0] shadow_val_q, shadow_val_d;
    logic [DIGITS-1:0]   shadow_dp_q, shadow_dp_d;
    logic [DIGITS-1:0]   shadow_en_q, shadow_en_d;
    logic [4*DIGITS-1:0] active_val_q, active_val_d;
    logic [DIGITS-1:0]   active_dp_q, active_dp_d;
    logic [DIGITS-1:0]   active_en_q, active_en_d;
    logic [6:0]          seg_q, seg_d;
    logic                dp_n_q, dp_n_d;
    logic [DIGITS-1:0]   an_q, an_d;
    logic                frame_done_q, frame_done_d;

    logic                slot_end;
    logic                boundary;
    logic                lit;
    logic [3:0]          cur_nib;

    // Hex to active-low abcdefg.
    function automatic logic [6:0] decode(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'b0000001;
            4'h1: s = 7'b1001111;
            4'h2: s = 7'b0010010;
            4'h3: s = 7'b0000110;
            4'h4: s = 7'b1001100;
            4'h5: s = 7'b0100100;
            4'h6: s = 7'b0100000;
            4'h7: s = 7'b0001111;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0000100;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b1100000;
            4'hC: s = 7'b0110001;
            4'hD: s = 7'b1000010;
            4'hE: s = 7'b0110000;
            default: s = 7'b0111000;
        endcase
        return s;
    endfunction

    // Scan position, double-buffer transfer and frame strobe.
    always_comb begin
        slot_end     = &slot_cnt_q;
        boundary     = slot_end && (idx_q == LastIdx);
        slot_cnt_d   = slot_cnt_q + 1'b1;
        idx_d        = idx_q;
        if (slot_end) begin
            idx_d = (idx_q == LastIdx) ? '0 : idx_q + 1'b1;
        end
        shadow_val_d = shadow_val_q;
        shadow_dp_d  = shadow_dp_q;
        shadow_en_d  = shadow_en_q;
        if (load) begin
            shadow_val_d = value_in;
            shadow_dp_d  = dp_in;
            shadow_en_d  = digit_en_in;
        end
        // Active takes the pre-load shadow, so a load on the boundary shows next frame.
        active_val_d = active_val_q;
        active_dp_d  = active_dp_q;
        active_en_d  = active_en_q;
        if (boundary) begin
            active_val_d = shadow_val_q;
            active_dp_d  = shadow_dp_q;
            active_en_d  = shadow_en_q;
        end
        frame_done_d = boundary;
    end

`ifdef SSD_LZS_EN
    logic [DIGITS-1:0] zero_from;
    logic              zero_run;

    // zero_from[k] is set when nibbles k..DIGITS-1 are all zero.
    always_comb begin
        zero_from = '0;
        zero_run  = 1'b1;
        for (int k = int'(DIGITS) - 1; k >= 0; k--) begin
            zero_run     = zero_run && (active_val_q[4*k +: 4] == 4'h0);
            zero_from[k] = zero_run;
        end
    end
`endif

    // Next cathode/anode pattern from the current scan position.
    always_comb begin
        seg_d   = 7'h7F;
        dp_n_d  = 1'b1;
        an_d    = '1;
        cur_nib = active_val_q[{idx_q, 2'b00} +: 4];
        lit     = active_en_q[idx_q] && (slot_cnt_q[SLOT_W-1 -: 4] <= bright);
        if (lit) begin
            an_d[idx_q] = 1'b0;
            seg_d       = decode(cur_nib);
            dp_n_d      = ~active_dp_q[idx_q];
`ifdef SSD_LZS_EN
            // Suppressed digit keeps its anode only to show a requested dp.
            if ((idx_q != '0) && zero_from[idx_q]) begin
                seg_d = 7'h7F;
                if (!active_dp_q[idx_q]) begin
                    an_d = '1;
                end
            end
`endif
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            slot_cnt_q   <= '0;
            idx_q        <= '0;
            shadow_val_q <= '0;
            shadow_dp_q  <= '0;
            shadow_en_q  <= '0;
            active_val_q <= '0;
            active_dp_q  <= '0;
            active_en_q  <= '0;
            seg_q        <= 7'h7F;
            dp_n_q       <= 1'b1;
            an_q         <= '1;
            frame_done_q <= 1'b0;
        end else begin
            slot_cnt_q   <= slot_cnt_d;
            idx_q        <= idx_d;
            shadow_val_q <= shadow_val_d;
            shadow_dp_q  <= shadow_dp_d;
            shadow_en_q  <= shadow_en_d;
            active_val_q <= active_val_d;
            active_dp_q  <= active_dp_d;
            active_en_q  <= active_en_d;
            seg_q        <= seg_d;
            dp_n_q       <= dp_n_d;
            an_q         <= an_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign seg        = seg_q;
    assign dp_n       = dp_n_q;
    assign an         = an_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_ssd_scan_n.sv
// Bench for ssd_scan_n with DIGITS=4, SLOT_W=4 (64-cycle frames).
// A reference model predicts {an, seg, dp_n, frame_done} for every clock and
// queues it; the DUT output is popped and compared 1 time unit after each edge.
// Directed windows of one frame tally anode and pattern counts against
// values worked out by hand.
module tb_ssd_scan_n;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        load = 1'b0;
    logic [15:0] value_in = '0;
    logic [3:0]  dp_in = '0;
    logic [3:0]  digit_en_in = '0;
    logic [3:0]  bright = 4'hF;
    logic [6:0]  seg;
    logic        dp_n;
    logic [3:0]  an;
    logic        frame_done;

    ssd_scan_n #(.DIGITS(4), .SLOT_W(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .load        (load),
        .value_in    (value_in),
        .dp_in       (dp_in),
        .digit_en_in (digit_en_in),
        .bright      (bright),
        .seg         (seg),
        .dp_n        (dp_n),
        .an          (an),
        .frame_done  (frame_done)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errs    = 0;

    logic [6:0] dec_tab [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                                 7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                                 7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                                 7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

    // Reference model state.
    logic [3:0]  m_slot = '0;
    int          m_idx = 0;
    logic [15:0] m_sval = '0, m_aval = '0;
    logic [3:0]  m_sdp = '0, m_adp = '0, m_sen = '0, m_aen = '0;

    logic [11:0] exp_q [$];

    // Tallies over a window.
    int          cnt_on, cnt_fd, cnt_pat;
    int          cnt_an [4];
    logic [11:0] pat;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_tally();
        cnt_on  = 0;
        cnt_fd  = 0;
        cnt_pat = 0;
        for (int k = 0; k < 4; k++) cnt_an[k] = 0;
    endtask

    // One clock: predict, push, advance, pop and compare, tally.
    task automatic cyc();
        logic [3:0]  e_an;
        logic [6:0]  e_seg;
        logic        e_dp, e_fd, on;
        logic [11:0] got, want;
        e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_fd = 1'b0;
        if (rst) begin
            m_slot = '0; m_idx = 0;
            m_sval = '0; m_sdp = '0; m_sen = '0;
            m_aval = '0; m_adp = '0; m_aen = '0;
        end else begin
            on = m_aen[m_idx] && (m_slot <= bright);
            if (on) begin
                e_an  = ~(4'b0001 << m_idx);
                e_seg = dec_tab[m_aval[m_idx*4 +: 4]];
                e_dp  = ~m_adp[m_idx];
`ifdef SSD_LZS_EN
                if (m_idx != 0 && (m_aval >> (m_idx * 4)) == 16'h0) begin
                    e_seg = 7'h7F;
                    if (!m_adp[m_idx]) e_an = 4'hF;
                end
`endif
            end
            e_fd = (m_slot == 4'hF) && (m_idx == 3);
            if (e_fd) begin
                m_aval = m_sval; m_adp = m_sdp; m_aen = m_sen;
            end
            if (load) begin
                m_sval = value_in; m_sdp = dp_in; m_sen = digit_en_in;
            end
            if (m_slot == 4'hF) m_idx = (m_idx + 1) % 4;
            m_slot = m_slot + 4'd1;
        end
        exp_q.push_back({e_an, e_seg, e_dp, e_fd});
        @(posedge clk);
        #1;
        want = exp_q.pop_front();
        got  = {an, seg, dp_n, frame_done};
        check("out", 32'(got), 32'(want));
        if (an != 4'hF) cnt_on++;
        if (frame_done) cnt_fd++;
        for (int k = 0; k < 4; k++) if (!an[k]) cnt_an[k]++;
        if ({an, seg, dp_n} == pat) cnt_pat++;
    endtask

    task automatic run(input int n);
        repeat (n) cyc();
    endtask

    // Advance until the frame_done sample, bounded.
    task automatic sync();
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            cyc();
            seen = frame_done;
        end
        check("sync", 32'(seen), 32'd1);
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] d, input logic [3:0] e);
        value_in = v; dp_in = d; digit_en_in = e; load = 1'b1;
        cyc();
        load = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic found;
        pat = '1;
        // Reset, then one blank frame with exactly one frame_done.
        rst = 1'b1;
        cyc();
        check("reset_an", 32'(an), 32'hF);
        check("reset_seg", 32'(seg), 32'h7F);
        check("reset_dp", 32'(dp_n), 32'd1);
        check("reset_fd", 32'(frame_done), 32'd0);
        rst = 1'b0;
        clear_tally();
        run(64);
        check("blank_on", 32'(cnt_on), 32'd0);
        check("blank_fd", 32'(cnt_fd), 32'd1);

        // 12AF, dp on digit 2, full brightness.
        do_load(16'h12AF, 4'b0100, 4'hF);
        sync();
        sync();
        clear_tally();
        pat = {4'b1110, 7'b0111000, 1'b1};
        run(64);
        check("d0_F", 32'(cnt_pat), 32'd16);
        check("full_on", 32'(cnt_on), 32'd64);
        check("fd_per_frame", 32'(cnt_fd), 32'd1);
        clear_tally();
        pat = {4'b1011, 7'b0010010, 1'b0};
        run(64);
        check("d2_2_dp", 32'(cnt_pat), 32'd16);
        pat = '1;

        // PWM levels.
        bright = 4'd0;
        clear_tally();
        run(64);
        for (int k = 0; k < 4; k++) check("bright0", 32'(cnt_an[k]), 32'd1);
        bright = 4'd7;
        clear_tally();
        run(64);
        for (int k = 0; k < 4; k++) check("bright7", 32'(cnt_an[k]), 32'd8);
        bright = 4'hF;

        // Load in the boundary cycle: old value for one more frame.
        sync();
        run(63);
        value_in = 16'h5555; dp_in = 4'b0000; digit_en_in = 4'hF; load = 1'b1;
        cyc();
        load = 1'b0;
        check("bnd_fd", 32'(frame_done), 32'd1);
        clear_tally();
        pat = {4'b1110, 7'b0111000, 1'b1};
        run(64);
        check("bnd_old", 32'(cnt_pat), 32'd16);
        clear_tally();
        pat = {4'b1110, 7'b0100100, 1'b1};
        run(64);
        check("bnd_new", 32'(cnt_pat), 32'd16);
        pat = '1;

        // Per-digit enable.
        do_load(16'h12AF, 4'b0000, 4'b0101);
        sync();
        sync();
        clear_tally();
        run(64);
        check("en_an0", 32'(cnt_an[0]), 32'd16);
        check("en_an1", 32'(cnt_an[1]), 32'd0);
        check("en_an2", 32'(cnt_an[2]), 32'd16);
        check("en_an3", 32'(cnt_an[3]), 32'd0);

        // Leading zeros.
        do_load(16'h0070, 4'b0000, 4'hF);
        sync();
        sync();
        clear_tally();
        run(64);
`ifdef SSD_LZS_EN
        check("lzs_on", 32'(cnt_on), 32'd32);
        check("lzs_an3", 32'(cnt_an[3]), 32'd0);
`else
        check("lzs_on", 32'(cnt_on), 32'd64);
        check("lzs_an3", 32'(cnt_an[3]), 32'd16);
`endif
        check("lzs_an0", 32'(cnt_an[0]), 32'd16);

        // Reset mid-slot while digit 2 is lit.
        do_load(16'h12AF, 4'b0100, 4'hF);
        sync();
        sync();
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            cyc();
            found = (an == 4'b1011);
        end
        check("d2_lit", 32'(found), 32'd1);
        run(3);
        rst = 1'b1;
        cyc();
        check("midrst_an", 32'(an), 32'hF);
        rst = 1'b0;
        clear_tally();
        run(64);
        check("midrst_cleared", 32'(cnt_on), 32'd0);
        check("midrst_fd", 32'(cnt_fd), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
